// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states and the default datapath width.
package muldiv_pkg;

    localparam int N_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: shift-add for multiply,
// restoring trial-subtract-shift for divide. Purely combinational.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         is_div,
    input  logic [N-1:0] acc_hi,
    input  logic [N-1:0] acc_lo,
    input  logic [N-1:0] opnd,
    output logic [N-1:0] next_hi,
    output logic [N-1:0] next_lo
);

    logic [N:0]   sum;
    logic [N:0]   shifted;
    logic [N-1:0] diff;

    // acc_lo holds the multiplier (LSB first) or the dividend (MSB first)
    always_comb begin
        sum     = {1'b0, acc_hi} + {1'b0, opnd};
        shifted = {acc_hi, acc_lo[N-1]};
        diff    = shifted[N-1:0] - opnd;
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (is_div) begin
            if (shifted >= {1'b0, opnd}) begin
                next_hi = diff;
                next_lo = {acc_lo[N-2:0], 1'b1};
            end else begin
                next_hi = shifted[N-1:0];
                next_lo = {acc_lo[N-2:0], 1'b0};
            end
        end else begin
            if (acc_lo[0]) begin
                next_hi = sum[N:1];
                next_lo = {sum[0], acc_lo[N-1:1]};
            end else begin
                next_hi = {1'b0, acc_hi[N-1:1]};
                next_lo = {acc_hi[0], acc_lo[N-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Define MULDIV_SIGNED_EN to build signed MULT/DIV; otherwise every op is unsigned.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N + 1);

    state_e         state;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic [N-1:0]   acc_hi;
    logic [N-1:0]   acc_lo;
    logic [N-1:0]   opnd;
    logic [N-1:0]   step_hi;
    logic [N-1:0]   step_lo;
    logic [N-1:0]   x_mag;
    logic [N-1:0]   y_mag;
    logic [N-1:0]   res_hi;
    logic [N-1:0]   res_lo;
    logic [2*N-1:0] prod;
    logic           start_div;
`ifdef MULDIV_SIGNED_EN
    logic           neg_q;
    logic           neg_r;
    logic           start_neg_q;
    logic           start_neg_r;
`endif

    assign start_div = op_is_div(op_e'(op));

    muldiv_step #(.N(N)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .opnd    (opnd),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

`ifdef MULDIV_SIGNED_EN
    // Magnitudes and result sign flags; the remainder follows the dividend sign
    always_comb begin
        x_mag       = x;
        y_mag       = y;
        start_neg_q = 1'b0;
        start_neg_r = 1'b0;
        if (op_is_signed(op_e'(op))) begin
            x_mag       = x[N-1] ? -x : x;
            y_mag       = y[N-1] ? -y : y;
            start_neg_q = x[N-1] ^ y[N-1];
            start_neg_r = start_div & x[N-1];
        end else begin
            x_mag       = x;
            y_mag       = y;
        end
    end
`else
    assign x_mag = x;
    assign y_mag = y;
`endif

    // Final HI/LO value written on the last iteration edge
    always_comb begin
        prod   = {step_hi, step_lo};
        res_hi = step_hi;
        res_lo = step_lo;
        if (is_div) begin
            if (opnd == {N{1'b0}}) begin
                res_lo = {N{1'b1}};
            end else begin
`ifdef MULDIV_SIGNED_EN
                if (neg_q) begin
                    res_lo = -step_lo;
                end else begin
                    res_lo = step_lo;
                end
`else
                res_lo = step_lo;
`endif
            end
`ifdef MULDIV_SIGNED_EN
            if (neg_r) begin
                res_hi = -step_hi;
            end else begin
                res_hi = step_hi;
            end
`endif
        end else begin
`ifdef MULDIV_SIGNED_EN
            if (neg_q) begin
                prod = -{step_hi, step_lo};
            end else begin
                prod = {step_hi, step_lo};
            end
`endif
            res_hi = prod[2*N-1:N];
            res_lo = prod[N-1:0];
        end
    end

    // Control FSM, iteration registers and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            hi     <= {N{1'b0}};
            lo     <= {N{1'b0}};
            cnt    <= {CW{1'b0}};
            is_div <= 1'b0;
            acc_hi <= {N{1'b0}};
            acc_lo <= {N{1'b0}};
            opnd   <= {N{1'b0}};
`ifdef MULDIV_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        dbz    <= 1'b0;
                        cnt    <= {CW{1'b0}};
                        is_div <= start_div;
                        acc_hi <= {N{1'b0}};
                        acc_lo <= start_div ? x_mag : y_mag;
                        opnd   <= start_div ? y_mag : x_mag;
`ifdef MULDIV_SIGNED_EN
                        neg_q  <= start_neg_q;
                        neg_r  <= start_neg_r;
`endif
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= ST_DONE;
                        hi    <= res_hi;
                        lo    <= res_lo;
                        dbz   <= is_div & (opnd == {N{1'b0}});
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops
// against an arithmetic reference model, busy-time interference and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [N-1:0] x, y, wdata;
    logic         busy, done, dbz;
    logic [N-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic on the architectural definition
    function automatic void ref_model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                                      output logic [N-1:0] eh, output logic [N-1:0] el, output logic ed);
        bit          sgn;
        longint      sa, sb;
        logic [63:0] p;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = (o[0] == 1'b0);
`endif
        ed = 1'b0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        if (o[1] == 1'b0) begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
            ed = 1'b1;
        end else begin
            el = 32'(sa / sb);
            eh = 32'(sa % sb);
        end
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one op from IDLE, scramble inputs afterwards, wait (bounded) for done
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output logic [N-1:0] rh, output logic [N-1:0] rl,
                          output logic rd, output bit stable);
        logic [N-1:0] h0, l0;
        op = o; x = a; y = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = $urandom; y = $urandom; op = 2'($urandom);
        h0 = hi; l0 = lo; lat = -1; stable = 1'b1;
        for (int k = 1; k <= N + 8; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k < N && (hi !== h0 || lo !== l0)) stable = 1'b0;
        end
        rh = hi; rl = lo; rd = dbz;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b want 0", dbz); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        rst = 1'b0;
    endtask

    task automatic test_mthi_mtlo();
        logic [N-1:0] a, b, eh, el;
        logic         ed;
        bit           seen;
        wdata = 32'h1234_5678; hi_we = 1'b1;
        @(posedge clk); #1; hi_we = 1'b0;
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi: got %h want 12345678", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL mthi_lo_kept: got %h want 0", lo); end
        wdata = 32'hCAFE_F00D; lo_we = 1'b1;
        @(posedge clk); #1; lo_we = 1'b0;
        total++; if (lo !== 32'hCAFE_F00D) begin bad++; $display("FAIL mtlo: got %h want cafef00d", lo); end
        total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); end
        a = $urandom; b = $urandom;
        ref_model(OP_MULTU, a, b, eh, el, ed);
        wdata = 32'hA5A5_5A5A; hi_we = 1'b1; start = 1'b1; op = OP_MULTU; x = a; y = b;
        @(posedge clk); #1; hi_we = 1'b0; start = 1'b0;
        total++; if (hi !== 32'hA5A5_5A5A) begin bad++; $display("FAIL mthi_with_start_hi: got %h want a5a55a5a", hi); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mthi_with_start_busy: got %b want 1", busy); end
        seen = 1'b0;
        for (int k = 2; k <= N + 8; k++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL mthi_with_start_done: got %b want 1", seen); end
        total++; if (hi !== eh || lo !== el) begin bad++; $display("FAIL mthi_with_start_result: got %h_%h want %h_%h", hi, lo, eh, el); end
    endtask

    task automatic test_directed();
        int           lat;
        logic [N-1:0] rh, rl, eh, el;
        logic         rd, ed;
        bit           st;
        run_op(OP_MULTU, 32'h3333_3333, 32'h0222_2222, lat, rh, rl, rd, st);
        total++; if (lat !== N + 1) begin bad++; $display("FAIL multu_latency: got %0d want %0d", lat, N + 1); end
        total++; if (rh !== 32'h006D_3A06 || rl !== 32'hCC5F_92C6) begin bad++; $display("FAIL multu_result: got %h_%h want 006d3a06_cc5f92c6", rh, rl); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL multu_stable: got %b want 1", st); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done: got %b want 0", busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
        run_op(OP_DIVU, 32'h3333_3333, 32'h0222_2222, lat, rh, rl, rd, st);
        total++; if (rl !== 32'h0000_0018 || rh !== 32'h0000_0003 || rd !== 1'b0) begin bad++; $display("FAIL divu_result: got %h_%h dbz=%b want 00000003_00000018 dbz=0", rh, rl, rd); end
        run_op(OP_DIVU, 32'd5, 32'd0, lat, rh, rl, rd, st);
        total++; if (rl !== 32'hFFFF_FFFF || rh !== 32'd5 || rd !== 1'b1) begin bad++; $display("FAIL divu_by_zero: got %h_%h dbz=%b want 00000005_ffffffff dbz=1", rh, rl, rd); end
        total++; if (lat !== N + 1) begin bad++; $display("FAIL div_latency: got %0d want %0d", lat, N + 1); end
`ifdef MULDIV_SIGNED_EN
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat, rh, rl, rd, st);
        total++; if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_signed: got %h_%h want ffffffff_fffffffe", rh, rl); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, rh, rl, rd, st);
        total++; if (rl !== 32'hFFFF_FFFD || rh !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_signed: got %h_%h want ffffffff_fffffffd", rh, rl); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, rh, rl, rd, st);
        total++; if (rl !== 32'h8000_0000 || rh !== 32'd0 || rd !== 1'b0) begin bad++; $display("FAIL div_minint: got %h_%h dbz=%b want 00000000_80000000 dbz=0", rh, rl, rd); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, rh, rl, rd, st);
        total++; if (rl !== 32'hFFFF_FFFF || rh !== 32'hFFFF_FFF9 || rd !== 1'b1) begin bad++; $display("FAIL div_signed_by_zero: got %h_%h dbz=%b want fffffff9_ffffffff dbz=1", rh, rl, rd); end
`else
        ref_model(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, eh, el, ed);
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat, rh, rl, rd, st);
        total++; if (rh !== eh || rl !== el) begin bad++; $display("FAIL mult_as_multu: got %h_%h want %h_%h", rh, rl, eh, el); end
        ref_model(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, eh, el, ed);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, rh, rl, rd, st);
        total++; if (rh !== eh || rl !== el) begin bad++; $display("FAIL div_as_divu: got %h_%h want %h_%h", rh, rl, eh, el); end
`endif
    endtask

    // Consecutive ops: each new start lands in the cycle done is high
    task automatic test_random_back_to_back();
        int           lat;
        logic [1:0]   o;
        logic [N-1:0] a, b, rh, rl, eh, el;
        logic         rd, ed;
        bit           st;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom); a = pick(); b = pick();
            ref_model(o, a, b, eh, el, ed);
            run_op(o, a, b, lat, rh, rl, rd, st);
            total++;
            if (lat !== N + 1 || rh !== eh || rl !== el || rd !== ed || st !== 1'b1) begin
                bad++;
                $display("FAIL random[%0d] op=%b x=%h y=%h: got lat=%0d %h_%h dbz=%b stable=%b want lat=%0d %h_%h dbz=%b stable=1",
                         i, o, a, b, lat, rh, rl, rd, st, N + 1, eh, el, ed);
            end
        end
    endtask

    task automatic test_ignore_while_busy();
        logic [1:0]   o;
        logic [N-1:0] a, b, eh, el, h0, l0;
        logic         ed;
        int           ndone, first;
        bit           stable;
        o = 2'($urandom); a = $urandom; b = $urandom | 32'd1;
        ref_model(o, a, b, eh, el, ed);
        op = o; x = a; y = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; h0 = hi; l0 = lo;
        ndone = 0; first = -1; stable = 1'b1;
        for (int k = 1; k <= 2 * N + 10; k++) begin
            if (k == 5) begin
                start = 1'b1; x = ~a; y = b + 32'd1; op = ~o;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (k == 8) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
            if (k < N && (hi !== h0 || lo !== l0)) stable = 1'b0;
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL busy_done_count: got %0d want 1", ndone); end
        total++; if (first !== N + 1) begin bad++; $display("FAIL busy_done_latency: got %0d want %0d", first, N + 1); end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL busy_hilo_stable: got %b want 1", stable); end
        total++; if (hi !== eh || lo !== el || dbz !== ed) begin bad++; $display("FAIL busy_result: got %h_%h dbz=%b want %h_%h dbz=%b", hi, lo, dbz, eh, el, ed); end
    endtask

    task automatic test_mid_reset();
        int           lat, ndone;
        logic [N-1:0] rh, rl;
        logic         rd;
        bit           st;
        run_op(OP_DIVU, 32'h0000_0077, 32'd0, lat, rh, rl, rd, st);
        rst = 1'b1; start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || dbz !== 1'b0) begin bad++; $display("FAIL rst_priority: got busy=%b %h_%h dbz=%b want busy=0 0_0 dbz=0", busy, hi, lo, dbz); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_priority_no_start: got %b want 0", busy); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rh, rl, rd, st);
        op = OP_MULTU; x = $urandom | 32'd1; y = $urandom | 32'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin bad++; $display("FAIL mid_run_reset: got busy=%b %h_%h done=%b want busy=0 0_0 done=0", busy, hi, lo, done); end
        ndone = 0;
        for (int k = 0; k < N + 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL mid_run_reset_quiet: got %0d active cycles want 0", ndone); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; x = 32'd0; y = 32'd0; wdata = 32'd0;
        test_reset();
        test_mthi_mtlo();
        test_directed();
        test_random_back_to_back();
        test_ignore_while_busy();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
